multicycle_main_control: RTL
============================

// Module: multicycle_main_control
// PURPOSE
// - Multicycle MIPS main control FSM; one step of the instruction per state.
// - Decodes opcode, sequences fetch/decode/execute/memory/writeback and drives all datapath enables.
// - Produces alu_op[1:0] for the ALU control unit, which combines it with funct to form alu_ctl.
// - Waits on a memory ready handshake and counts retired instructions.
// PARAMETERS
// - CNT_W  32  width of retired-instruction counter
// PORTS
// - clk            in   1      system clock, rising edge
// - rst_n          in   1      asynchronous, active-low reset
// - opcode         in   6      instr[31:26] from instruction register
// - mem_ready      in   1      memory access completes this cycle
// - zero           in   1      ALU zero flag, used for BEQ
// - pc_write       out  1      unconditional PC load
// - pc_write_cond  out  1      PC load qualified by zero (datapath ANDs)
// - i_or_d         out  1      0=PC addresses memory, 1=ALUOut
// - mem_read       out  1      memory read request
// - mem_write      out  1      memory write request
// - ir_write       out  1      load instruction register
// - mem_to_reg     out  1      1=write MDR to register file, 0=ALUOut
// - reg_write      out  1      register file write enable
// - reg_dst        out  1      1=rd, 0=rt
// - alu_src_a      out  1      0=PC, 1=rs
// - alu_src_b      out  2      00=rt 01=const 4 10=sign-ext imm 11=imm<<2
// - alu_op         out  2      00=add 01=sub 10=use funct
// - pc_source      out  2      00=ALU result 01=ALUOut 10=jump target
// - instr_done     out  1      1-cycle pulse in an instruction's final cycle
// - illegal_op     out  1      1-cycle pulse in DECODE for an unsupported opcode
// - instr_count    out  CNT_W  retired instruction count
// BEHAVIOUR
// - Opcodes: RTYPE=000000 LW=100011 SW=101011 BEQ=000100 J=000010.
// - States: IDLE FETCH DECODE MEMADR MEMRD MEMWB MEMWR EXEC ALUWB BRANCH JUMP. Moore outputs come from the state only, except the mem_ready-qualified outputs noted below.
// - Reset: state=IDLE, instr_count=0. Every output is 0 in IDLE. IDLE always goes to FETCH on the next clock.
// - FETCH: mem_read=1, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00. ir_write and pc_write are asserted only when mem_ready=1. Stay in FETCH while mem_ready=0; go to DECODE when it is 1.
// - DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target goes to ALUOut).
//   - LW/SW -> MEMADR; RTYPE -> EXEC; BEQ -> BRANCH; J -> JUMP.
//   - Any other opcode: pulse illegal_op and return to FETCH. Not counted as retired.
// - MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. LW -> MEMRD, SW -> MEMWR.
// - MEMRD: mem_read=1, i_or_d=1. Hold until mem_ready=1, then go to MEMWB.
// - MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1 -> FETCH.
// - MEMWR: mem_write=1, i_or_d=1. Hold until mem_ready=1. In that cycle instr_done=1 -> FETCH.
// - EXEC: alu_src_a=1, alu_src_b=00, alu_op=10 -> ALUWB.
// - ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1 -> FETCH.
// - BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, instr_done=1 -> FETCH. Counted whether or not the branch is taken.
// - JUMP: pc_write=1, pc_source=10, instr_done=1 -> FETCH.
// - CPI: R-type 4, LW 5, SW 4, BEQ 3, J 3. Each cycle of mem_ready=0 in a memory state adds one cycle.
// - instr_count increments by 1 on each clock where instr_done=1. It wraps from all-ones to 0.
// - The opcode is sampled in DECODE and again in MEMADR. The datapath must hold the IR stable after FETCH.
// - zero is not registered here and has no effect on FSM transitions.
// - Reset asserted mid-instruction: outputs drop to 0 asynchronously and the in-flight instruction is abandoned, not counted.
// - Unreachable state encodings go to IDLE.
// CONFIGURATION
// - CONTROL_JUMP_EN defined: J decodes to JUMP as above.
// - CONTROL_JUMP_EN undefined: the JUMP state is not built. J is treated as illegal (illegal_op pulse, back to FETCH), and pc_source never equals 10.
// STRUCTURE
// - Package mc_ctrl_pkg holds:
//   - state_t enum (4-bit)
//   - opcode localparams (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J)
//   - ALUOP_ADD/SUB/FUNCT and ALUSRCB_*/PCSRC_* constants
// - One sub-module, mc_ctrl_outdec: combinational state + mem_ready -> control outputs. The top module holds the state register, next-state logic and counter.
// TESTING
// - Reset: hold rst_n=0 for 3 cycles -> all outputs 0, instr_count=0. After release, IDLE then FETCH with mem_read=1.
// - R-type, opcode=000000, mem_ready=1 throughout:
//   - FETCH cycle: ir_write=1, pc_write=1.
//   - EXEC cycle: alu_op=10.
//   - ALUWB cycle: reg_write=1, reg_dst=1, instr_done=1.
//   - Total 4 cycles; instr_count 0->1.
// - LW with mem_ready low for 2 cycles in MEMRD -> 2 extra MEMRD cycles with mem_read=1, i_or_d=1. MEMWB asserts reg_write=1, mem_to_reg=1. Total 7 cycles.
// - BEQ -> BRANCH asserts alu_op=01, pc_write_cond=1, pc_source=01 for zero=0 and for zero=1. Each takes 3 cycles and is counted.
// - opcode=111111 -> illegal_op pulses in DECODE, next state FETCH, instr_count unchanged. Opcode 000010 behaves the same when CONTROL_JUMP_EN is undefined.
// - Preload instr_count=2^CNT_W-1 by forcing, then retire SW -> wraps to 0. rst_n dropped during MEMWR -> outputs 0 immediately.

Source files
------------

// File: rtl/multicycle_main_control_pkg.sv
// Shared types and constants for the multicycle MIPS main control FSM.
// Optional feature macro: CONTROL_JUMP_EN (J instruction support).
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] ALUSRCB_RT    = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
    localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // All datapath control outputs in one bundle.
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       reg_dst;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
        logic       illegal_op;
    } ctrl_t;

    // True for opcodes this controller knows how to sequence.
    function automatic logic op_legal(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ: return 1'b1;
`ifdef CONTROL_JUMP_EN
            OP_J:                           return 1'b1;
`endif
            default:                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_main_control_if.sv
// Controller <-> datapath bundle: opcode/handshake in, control enables out.
interface multicycle_main_control_if #(
    parameter int CNT_W = 32
) ();
    logic [5:0]       opcode;
    logic             mem_ready;
    logic             zero;
    logic             pc_write;
    logic             pc_write_cond;
    logic             i_or_d;
    logic             mem_read;
    logic             mem_write;
    logic             ir_write;
    logic             mem_to_reg;
    logic             reg_write;
    logic             reg_dst;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic [1:0]       pc_source;
    logic             instr_done;
    logic             illegal_op;
    logic [CNT_W-1:0] instr_count;

    // Controller side.
    modport master (
        input  opcode, mem_ready, zero,
        output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_write, reg_dst, alu_src_a, alu_src_b, alu_op,
               pc_source, instr_done, illegal_op, instr_count
    );

    // Datapath side.
    modport slave (
        output opcode, mem_ready, zero,
        input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_write, reg_dst, alu_src_a, alu_src_b, alu_op,
               pc_source, instr_done, illegal_op, instr_count
    );
endinterface

// File: rtl/multicycle_main_control_outdec.sv
// Output decoder: maps the current state (plus mem_ready for the handshake
// qualified enables) onto the datapath control bundle.
// Optional feature macro: CONTROL_JUMP_EN (builds the JUMP state outputs).
module mc_ctrl_outdec
    import mc_ctrl_pkg::*;
(
    input  state_t state_i,
    input  logic   mem_ready_i,
    input  logic   op_legal_i,
    output ctrl_t  ctrl_o
);

    // Moore decode of control enables; IDLE and unknown states drive all zero.
    always_comb begin
        // NOTE: assign a default to every output first so no path leaves a value unassigned and infers a latch.
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.alu_src_b = ALUSRCB_FOUR;
                ctrl_o.alu_op    = ALUOP_ADD;
                ctrl_o.pc_source = PCSRC_ALU;
                ctrl_o.ir_write  = mem_ready_i;
                ctrl_o.pc_write  = mem_ready_i;
            end
            S_DECODE: begin
                ctrl_o.alu_src_b  = ALUSRCB_IMMSH;
                ctrl_o.alu_op     = ALUOP_ADD;
                ctrl_o.illegal_op = ~op_legal_i;
            end
            S_MEMADR: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = ALUSRCB_IMM;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            S_MEMWR: begin
                ctrl_o.mem_write  = 1'b1;
                ctrl_o.i_or_d     = 1'b1;
                ctrl_o.instr_done = mem_ready_i;
            end
            S_EXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = ALUSRCB_RT;
                ctrl_o.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.reg_dst    = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            S_BRANCH: begin
                ctrl_o.alu_src_a     = 1'b1;
                ctrl_o.alu_src_b     = ALUSRCB_RT;
                ctrl_o.alu_op        = ALUOP_SUB;
                ctrl_o.pc_write_cond = 1'b1;
                ctrl_o.pc_source     = PCSRC_ALUOUT;
                ctrl_o.instr_done    = 1'b1;
            end
`ifdef CONTROL_JUMP_EN
            S_JUMP: begin
                ctrl_o.pc_write   = 1'b1;
                ctrl_o.pc_source  = PCSRC_JUMP;
                ctrl_o.instr_done = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_main_control.sv
// Multicycle MIPS main control: state register, next-state sequencing and
// retired-instruction counter; outputs come from mc_ctrl_outdec.
// Optional feature macro: CONTROL_JUMP_EN (J decodes to the JUMP state).
module multicycle_main_control
    import mc_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    multicycle_main_control_if.master    bus
);

    state_t           state_q, state_d;
    ctrl_t            ctrl;
    logic [CNT_W-1:0] cnt_q;
    logic             legal;
    logic             unused_zero;

    // zero is consumed by the datapath's PC-write gating, not by the FSM.
    assign unused_zero = bus.zero;
    assign legal       = op_legal(bus.opcode);

    // State register; reset abandons any in-flight instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state sequencing; opcode is read in DECODE and again in MEMADR.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
`ifdef CONTROL_JUMP_EN
                    OP_J:         state_d = S_JUMP;
`endif
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (bus.mem_ready) state_d = S_MEMWB;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  if (bus.mem_ready) state_d = S_FETCH;
            S_EXEC:   state_d = S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
`ifdef CONTROL_JUMP_EN
            S_JUMP:   state_d = S_FETCH;
`endif
            default:  state_d = S_IDLE;
        endcase
    end

    // Retired-instruction counter; wraps naturally at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)               cnt_q <= '0;
        else if (ctrl.instr_done) cnt_q <= cnt_q + CNT_W'(1);
    end

    mc_ctrl_outdec u_outdec (
        .state_i     (state_q),
        .mem_ready_i (bus.mem_ready),
        .op_legal_i  (legal),
        .ctrl_o      (ctrl)
    );

    assign bus.pc_write      = ctrl.pc_write;
    assign bus.pc_write_cond = ctrl.pc_write_cond;
    assign bus.i_or_d        = ctrl.i_or_d;
    assign bus.mem_read      = ctrl.mem_read;
    assign bus.mem_write     = ctrl.mem_write;
    assign bus.ir_write      = ctrl.ir_write;
    assign bus.mem_to_reg    = ctrl.mem_to_reg;
    assign bus.reg_write     = ctrl.reg_write;
    assign bus.reg_dst       = ctrl.reg_dst;
    assign bus.alu_src_a     = ctrl.alu_src_a;
    assign bus.alu_src_b     = ctrl.alu_src_b;
    assign bus.alu_op        = ctrl.alu_op;
    assign bus.pc_source     = ctrl.pc_source;
    assign bus.instr_done    = ctrl.instr_done;
    assign bus.illegal_op    = ctrl.illegal_op;
    assign bus.instr_count   = cnt_q;

endmodule
